// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM state encoding and memory sizing.
package mem_stage_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam int DEPTH_DEF = 64;
  localparam int IDX_W     = $clog2(DEPTH_DEF);
endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory with synchronous write and registered read.
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = IDX_W
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch/jump resolution, two-cycle aligned memory access FSM, MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inAdder,
  input  logic        inZf,
  input  logic [31:0] inOutAlu,
  input  logic [31:0] inRD2,
  input  logic [4:0]  inMux5b,
  input  logic [31:0] inJump,
  input  logic        inBranch,
  input  logic        inJumpEn,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic        inRegWrite,
  input  logic        inMemToReg,
  output logic        outPcSrc,
  output logic [31:0] outPcTarget,
  output logic        outStall,
  output logic [31:0] outReadData,
  output logic [31:0] outAluResult,
  output logic [4:0]  outMux5b,
  output logic        outRegWrite,
  output logic        outMemToReg,
  output logic        outMisaligned
);

  localparam int AW = $clog2(DEPTH);

  logic [0:0]  state_q, state_d;
  logic [31:0] read_data_q, read_data_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [4:0]  mux5b_q, mux5b_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        misaligned_q, misaligned_d;

  logic          access, aligned, load_only;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          unused_addr_bits;

  assign outPcSrc    = inJumpEn | (inBranch & inZf);
  assign outPcTarget = inJumpEn ? inJump : inAdder;

  assign access           = inMemRead | inMemWrite;
  assign aligned          = (inOutAlu[1:0] == 2'b00);
  assign load_only        = inMemRead & ~inMemWrite;
  assign mem_addr         = inOutAlu[AW+1:2];
  assign unused_addr_bits = ^inOutAlu[31:AW+2];

  always_comb begin
    state_d      = state_q;
    outStall     = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    read_data_d  = '0;
    alu_result_d = inOutAlu;
    mux5b_d      = inMux5b;
    reg_write_d  = inRegWrite;
    mem_to_reg_d = inMemToReg;
    misaligned_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (access && aligned) begin
        // Launch the registered read now; the MEM/WB register holds a bubble meanwhile.
        outStall     = 1'b1;
        state_d      = ST_WAIT;
        mem_re       = load_only;
        alu_result_d = '0;
        mux5b_d      = '0;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
      end else if (access) begin
        misaligned_d = 1'b1;
        reg_write_d  = 1'b0;
      end
    end else begin
      state_d     = ST_IDLE;
      mem_we      = inMemWrite;
      read_data_d = load_only ? mem_rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      read_data_q  <= '0;
      alu_result_q <= '0;
      mux5b_q      <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      mux5b_q      <= mux5b_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      misaligned_q <= misaligned_d;
    end
  end

  // A reset landing on the WAIT cycle cancels the store it would have completed.
  data_memory #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_dmem (
    .clk    (clk),
    .we_i   (mem_we & ~rst),
    .re_i   (mem_re),
    .addr_i (mem_addr),
    .wdata_i(inRD2),
    .rdata_o(mem_rdata)
  );

  assign outReadData   = read_data_q;
  assign outAluResult  = alu_result_q;
  assign outMux5b      = mux5b_q;
  assign outRegWrite   = reg_write_q;
  assign outMemToReg   = mem_to_reg_q;
  assign outMisaligned = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, reset corner cases and randomized traffic.
module tb_mem_stage;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inAdder, inOutAlu, inRD2, inJump;
  logic        inZf, inBranch, inJumpEn, inMemRead, inMemWrite, inRegWrite, inMemToReg;
  logic [4:0]  inMux5b;
  logic        outPcSrc, outStall, outRegWrite, outMemToReg, outMisaligned;
  logic [31:0] outPcTarget, outReadData, outAluResult;
  logic [4:0]  outMux5b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_m [DEPTH];

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  rd5;
    logic        mr, mw, rw, m2r;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  mem_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .inAdder(inAdder), .inZf(inZf), .inOutAlu(inOutAlu),
    .inRD2(inRD2), .inMux5b(inMux5b), .inJump(inJump), .inBranch(inBranch),
    .inJumpEn(inJumpEn), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
    .inRegWrite(inRegWrite), .inMemToReg(inMemToReg), .outPcSrc(outPcSrc),
    .outPcTarget(outPcTarget), .outStall(outStall), .outReadData(outReadData),
    .outAluResult(outAluResult), .outMux5b(outMux5b), .outRegWrite(outRegWrite),
    .outMemToReg(outMemToReg), .outMisaligned(outMisaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] rd5,
                              input logic mr, input logic mw, input logic rw, input logic m2r,
                              input logic [31:0] exp_data, input logic exp_mis);
    vec_t v;
    v.alu = alu; v.rd2 = rd2; v.rd5 = rd5; v.mr = mr; v.mw = mw; v.rw = rw; v.m2r = m2r;
    v.exp_data = exp_data; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic check_mw_zero(input string nm);
    chk({nm, "_rdata"}, outReadData, 32'h0);
    chk({nm, "_alu"}, outAluResult, 32'h0);
    chk({nm, "_rd5"}, {27'h0, outMux5b}, 32'h0);
    chk({nm, "_rw"}, {31'h0, outRegWrite}, 32'h0);
    chk({nm, "_m2r"}, {31'h0, outMemToReg}, 32'h0);
    chk({nm, "_mis"}, {31'h0, outMisaligned}, 32'h0);
  endtask

  // Executes one instruction against the reference model: aligned memory ops cost two cycles.
  task automatic run_instr(input vec_t v, output logic [31:0] got_data, output logic got_mis);
    logic        acc, alg, st;
    logic [31:0] e_data;
    int unsigned idx;
    acc    = v.mr | v.mw;
    alg    = (v.alu % 4) == 0;
    st     = acc && alg;
    idx    = (v.alu / 4) % DEPTH;
    e_data = (v.mr && !v.mw && alg) ? mem_m[idx] : 32'h0;
    inOutAlu = v.alu; inRD2 = v.rd2; inMux5b = v.rd5;
    inMemRead = v.mr; inMemWrite = v.mw; inRegWrite = v.rw; inMemToReg = v.m2r;
    #1;
    chk("stall_issue", {31'h0, outStall}, {31'h0, st});
    if (st) begin
      @(posedge clk); #1;
      chk("bubble_rw", {31'h0, outRegWrite}, 32'h0);
      chk("bubble_alu", outAluResult, 32'h0);
      chk("bubble_rd5", {27'h0, outMux5b}, 32'h0);
      chk("wait_stall", {31'h0, outStall}, 32'h0);
    end
    @(posedge clk); #1;
    chk("rdata", outReadData, e_data);
    chk("alu", outAluResult, v.alu);
    chk("rd5", {27'h0, outMux5b}, {27'h0, v.rd5});
    chk("rw", {31'h0, outRegWrite}, {31'h0, (acc && !alg) ? 1'b0 : v.rw});
    chk("m2r", {31'h0, outMemToReg}, {31'h0, v.m2r});
    chk("mis", {31'h0, outMisaligned}, {31'h0, acc && !alg});
    if (st && v.mw) mem_m[idx] = v.rd2;
    got_data = outReadData;
    got_mis  = outMisaligned;
  endtask

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    logic [31:0] gd;
    logic        gm;
    logic        e_src;
    logic [31:0] e_tgt;

    rst = 1'b1;
    inAdder = '0; inZf = 0; inOutAlu = '0; inRD2 = '0; inMux5b = '0; inJump = '0;
    inBranch = 0; inJumpEn = 0; inMemRead = 0; inMemWrite = 0; inRegWrite = 0; inMemToReg = 0;
    repeat (2) @(posedge clk);
    #1;
    check_mw_zero("reset");
    chk("reset_stall", {31'h0, outStall}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = 32'h0;
      run_instr(mk(i * 4, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0), gd, gm);
    end

    tbl.push_back(mk(32'h10, 32'hDEADBEEF, 5'd0, 0, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(32'h10, 32'h0, 5'd3, 1, 0, 1, 1, 32'hDEADBEEF, 0));
    tbl.push_back(mk(32'h5, 32'h0, 5'd9, 0, 0, 1, 0, 32'h0, 0));
    tbl.push_back(mk(32'h13, 32'h0, 5'd4, 1, 0, 1, 1, 32'h0, 1));
    tbl.push_back(mk(32'h100, 32'hA5, 5'd0, 0, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(32'h0, 32'h0, 5'd7, 1, 0, 1, 1, 32'hA5, 0));
    tbl.push_back(mk(32'h8, 32'h77, 5'd2, 1, 1, 1, 1, 32'h0, 0));
    tbl.push_back(mk(32'h8, 32'h0, 5'd2, 1, 0, 1, 1, 32'h77, 0));
    tbl.push_back(mk(32'h10, 32'h0, 5'd5, 1, 0, 1, 1, 32'hDEADBEEF, 0));
    tbl.push_back(mk(32'h10, 32'h11111111, 5'd0, 0, 1, 0, 0, 32'h0, 0));
    tbl.push_back(mk(32'h10, 32'h0, 5'd5, 1, 0, 1, 1, 32'h11111111, 0));
    tbl.push_back(mk(32'h21, 32'h99, 5'd0, 0, 1, 0, 0, 32'h0, 1));
    tbl.push_back(mk(32'h20, 32'h0, 5'd6, 1, 0, 1, 1, 32'h0, 0));
    foreach (tbl[i]) begin
      run_instr(tbl[i], gd, gm);
      chk("tbl_data", gd, tbl[i].exp_data);
      chk("tbl_mis", {31'h0, gm}, {31'h0, tbl[i].exp_mis});
    end

    inBranch = 1; inZf = 1; inAdder = 32'h40; inJumpEn = 0; inJump = 32'h100;
    #1;
    chk("br_src", {31'h0, outPcSrc}, 32'h1);
    chk("br_tgt", outPcTarget, 32'h40);
    inJumpEn = 1;
    #1;
    chk("jmp_src", {31'h0, outPcSrc}, 32'h1);
    chk("jmp_tgt", outPcTarget, 32'h100);
    inJumpEn = 0; inZf = 0;
    #1;
    chk("nobr_src", {31'h0, outPcSrc}, 32'h0);
    inBranch = 0;

    // Reset must clear registered outputs that hold live data.
    inOutAlu = 32'h1234; inMux5b = 5'd17; inRegWrite = 1; inMemToReg = 1; inMemRead = 0; inMemWrite = 0;
    @(posedge clk); #1;
    chk("pre_rst_alu", outAluResult, 32'h1234);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check_mw_zero("rst_clear");

    // Reset during WAIT cancels the pending store.
    inOutAlu = 32'h20; inRD2 = 32'h55; inMux5b = 5'd0; inMemWrite = 1; inMemRead = 0;
    inRegWrite = 0; inMemToReg = 0;
    #1;
    chk("rstw_stall", {31'h0, outStall}, 32'h1);
    @(posedge clk); #1;
    chk("rstw_wait", {31'h0, outStall}, 32'h0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check_mw_zero("rstw");
    chk("rstw_idle", {31'h0, outStall}, 32'h1);
    run_instr(mk(32'h20, 32'h0, 5'd8, 1, 0, 1, 1, 32'h0, 0), gd, gm);
    chk("rstw_data", gd, 32'h0);

    for (int i = 0; i < 300; i++) begin
      v.alu = $urandom;
      if ($urandom_range(0, 3) != 0) v.alu[1:0] = 2'b00;
      v.rd2 = $urandom; v.rd5 = 5'($urandom);
      v.mr = 1'($urandom); v.mw = 1'($urandom);
      v.rw = 1'($urandom); v.m2r = 1'($urandom);
      v.exp_data = '0; v.exp_mis = 0;
      inBranch = 1'($urandom); inZf = 1'($urandom); inJumpEn = 1'($urandom);
      inAdder = $urandom; inJump = $urandom;
      e_src = inJumpEn || (inBranch && inZf);
      e_tgt = inJumpEn ? inJump : inAdder;
      #1;
      chk("rnd_src", {31'h0, outPcSrc}, {31'h0, e_src});
      chk("rnd_tgt", outPcTarget, e_tgt);
      run_instr(v, gd, gm);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: DEPTH, 64, number of 32-bit data-memory words (power of two, 4..1024).
REQ-002 clk  input  1  single clock, all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 inAdder  input  32  branch target from the EX/MEM register.
REQ-005 inZf  input  1  ALU zero flag.
REQ-006 inOutAlu  input  32  ALU result / byte address.
REQ-007 inRD2  input  32  store data.
REQ-008 inMux5b  input  5  destination register number.
REQ-009 inJump  input  32  jump target.
REQ-010 inBranch, inJumpEn, inMemRead, inMemWrite, inRegWrite, inMemToReg  input  1 each  control bits for the current instruction.
REQ-011 outPcSrc  output  1  redirect PC this cycle (combinational).
REQ-012 outPcTarget  output  32  redirect address (combinational).
REQ-013 outStall  output  1  upstream must hold all inputs stable next cycle (combinational).
REQ-014 outReadData, outAluResult  output  32 each  MEM/WB registered load data and ALU result.
REQ-015 outMux5b  output  5; outRegWrite, outMemToReg, outMisaligned  output  1 each  MEM/WB registered.

Function
REQ-016 outPcSrc SHALL equal inJumpEn | (inBranch & inZf); outPcTarget SHALL equal inJump when inJumpEn=1, else inAdder; both are independent of FSM state.
REQ-017 Memory word index SHALL be inOutAlu[log2(DEPTH)+1:2]; higher address bits are ignored (wrap modulo DEPTH words).
REQ-018 An access is "aligned" when inOutAlu[1:0]=2'b00; the FSM has exactly two states, IDLE and WAIT.
REQ-019 IDLE, no aligned access requested: outStall=0; MEM/WB register captures inputs at the next posedge (latency 1).
REQ-020 IDLE, aligned inMemRead or inMemWrite: outStall=1; next state WAIT; MEM/WB register loads a bubble (all fields 0).
REQ-021 WAIT: outStall=0; store performed at the posedge ending WAIT; load data captured into outReadData at that same edge with the other fields; next state IDLE.
REQ-022 inMemRead and inMemWrite both 1: write performed, read suppressed, outReadData=0.
REQ-023 Misaligned access: no memory access, no stall, no state change; MEM/WB captures with outMisaligned=1, outRegWrite=0, outReadData=0.
REQ-024 Non-load instructions SHALL present outReadData=0.
REQ-025 Back-to-back memory instructions SHALL each take 2 cycles; a load followed by a store to the same word SHALL read the pre-store value.
REQ-026 Inputs changing while in WAIT are a protocol violation; the block uses the values present in WAIT.

Reset
REQ-027 rst=1 at a posedge SHALL force state IDLE and clear every MEM/WB output to 0; combinational outputs follow inputs.
REQ-028 rst asserted during WAIT SHALL suppress the pending store; memory contents are never cleared by reset.

Structure
REQ-029 Shared package holds the state encoding (IDLE=0, WAIT=1), the DEPTH default, and the index-width constant.
REQ-030 One sub-module data_memory (synchronous write, synchronous read, DEPTH x 32); FSM and MEM/WB register live in mem_stage.

Verification
REQ-031 Store 0xDEADBEEF to 0x10, then load 0x10 -> outStall high one cycle per access; outReadData=0xDEADBEEF two cycles after load issue, outMemToReg=1.
REQ-032 R-type, inOutAlu=0x00000005, inMux5b=9, inRegWrite=1 -> next cycle outAluResult=5, outMux5b=9, outRegWrite=1, outStall never high.
REQ-033 inBranch=1, inZf=1, inAdder=0x40 -> outPcSrc=1, outPcTarget=0x40 same cycle; with inJumpEn=1, inJump=0x100 -> outPcTarget=0x100.
REQ-034 Load from 0x13 -> no stall, outMisaligned=1, outRegWrite=0, outReadData=0 next cycle.
REQ-035 Store 0x55 to 0x20 with rst pulsed during WAIT, then load 0x20 -> original value (0 after initial write of 0) returned, all MEM/WB outputs 0 after reset edge.
REQ-036 DEPTH=64, store 0xA5 to 0x100 then load 0x000 -> 0xA5 (address wrap).
